// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the board-memory arbiter slice.
// Holds the arbiter FSM state encoding, default address/data widths of the board
// memory, the board-cell data encodings and a small index-width helper.
package go_mem_pkg;

  localparam int unsigned DefAddrW   = 6;
  localparam int unsigned DefDataW   = 8;
  localparam int unsigned BoardCells = 1 << DefAddrW;

  // Board-cell contents as stored in memory.
  localparam logic [DefDataW-1:0] CellEmpty = 8'h00;
  localparam logic [DefDataW-1:0] CellBlack = 8'h01;
  localparam logic [DefDataW-1:0] CellWhite = 8'h02;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } arb_state_e;

  // Width of an index into n items; never zero so single-port builds stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle of the board-memory arbiter.
// slave  : arbiter side (takes requests and memory responses, drives memory and completions)
// master : environment side (requesters plus memory model)
interface mem_arbiter_if import go_mem_pkg::*; #(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) ();

  logic [N_PORTS-1:0]        req_en;
  logic [N_PORTS-1:0]        req_wr_en;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_wr_data;
  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS-1:0]        req_err;
  logic [DATA_W-1:0]         rd_data;
  logic                      mem_en;
  logic                      mem_wr_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wr_data;
  logic                      mem_valid;
  logic [DATA_W-1:0]         mem_rd_data;
  logic [N_PORTS-1:0]        grant;

  modport slave (
    input  req_en, req_wr_en, req_addr, req_wr_data, mem_valid, mem_rd_data,
    output req_valid, req_err, rd_data, mem_en, mem_wr_en, mem_addr, mem_wr_data, grant
  );

  modport master (
    output req_en, req_wr_en, req_addr, req_wr_data, mem_valid, mem_rd_data,
    input  req_valid, req_err, rd_data, mem_en, mem_wr_en, mem_addr, mem_wr_data, grant
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector.
// req_i  : request vector
// last_i : index of the most recent winner; search starts at (last_i + 1) mod N_PORTS
// gnt_o  : one-hot winner (zero when no request)
// idx_o  : winner index
// any_o  : at least one request present
module rr_pick import go_mem_pkg::*; #(
  parameter int unsigned N_PORTS = 3,
  localparam int unsigned IdxW   = idx_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    // k = N_PORTS wraps back to last_i itself, so it has the lowest priority.
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = IdxW'((int'(last_i) + k) % N_PORTS);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving N_PORTS requesters access to a single board memory.
// clk : rising-edge clock
// rst : synchronous active-high reset
// bus : mem_arbiter_if.slave
//   req_en/req_wr_en/req_addr/req_wr_data : per-port requests (packed vectors)
//   req_valid/req_err                     : one-cycle completion / timeout pulses
//   rd_data                               : registered read data, valid with req_valid
//   mem_en/mem_wr_en/mem_addr/mem_wr_data : memory command, held through the transaction
//   mem_valid/mem_rd_data                 : memory completion and read data
//   grant                                 : one-hot memory owner, zero when idle
module mem_arbiter import go_mem_pkg::*; #(
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = idx_w(N_PORTS);
  localparam int unsigned CntW = idx_w(TIMEOUT);

  arb_state_e          state_q;
  logic [N_PORTS-1:0]  grant_q;
  logic [IdxW-1:0]     last_q;
  logic [CntW-1:0]     cnt_q;
  logic [N_PORTS-1:0]  req_valid_q;
  logic [N_PORTS-1:0]  req_err_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                mem_en_q;
  logic                mem_wr_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;

  logic [N_PORTS-1:0]  win_gnt;
  logic [IdxW-1:0]     win_idx;
  logic                win_any;

  rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_rr_pick (
    .req_i  (bus.req_en),
    .last_i (last_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      last_q        <= IdxW'(N_PORTS - 1);
      cnt_q         <= '0;
      req_valid_q   <= '0;
      req_err_q     <= '0;
      rd_data_q     <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          req_valid_q <= '0;
          req_err_q   <= '0;
          if (win_any) begin
            state_q       <= StBusy;
            grant_q       <= win_gnt;
            last_q        <= win_idx;
            cnt_q         <= '0;
            mem_en_q      <= 1'b1;
            mem_wr_en_q   <= bus.req_wr_en[win_idx];
            mem_addr_q    <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wr_data_q <= bus.req_wr_data[win_idx*DATA_W +: DATA_W];
          end
        end
        StBusy: begin
          // A response arriving on the last allowed cycle still counts as success.
          if (bus.mem_valid) begin
            state_q     <= StDone;
            mem_en_q    <= 1'b0;
            req_valid_q <= grant_q;
            if (!mem_wr_en_q) begin
              rd_data_q <= bus.mem_rd_data;
            end
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q     <= StDone;
            mem_en_q    <= 1'b0;
            req_valid_q <= grant_q;
            req_err_q   <= grant_q;
            rd_data_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // Requests seen here are ignored; arbitration resumes next cycle.
          state_q     <= StIdle;
          grant_q     <= '0;
          req_valid_q <= '0;
          req_err_q   <= '0;
        end
        default: begin
          state_q  <= StIdle;
          grant_q  <= '0;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.req_valid   = req_valid_q;
  assign bus.req_err     = req_err_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): N_PORTS, 3, number of requesters; ADDR_W, 6, board-cell address width; DATA_W, 8, memory data width; TIMEOUT, 1024, max cycles to wait for mem_valid.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_en  in  N_PORTS  per-port request level, held until that port's req_valid.
REQ-005 req_wr_en  in  N_PORTS  per-port write(1)/read(0), stable while req_en high.
REQ-006 req_addr  in  N_PORTS*ADDR_W  packed per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-007 req_wr_data  in  N_PORTS*DATA_W  packed per-port write data.
REQ-008 req_valid  out  N_PORTS  one-cycle completion pulse to the granted port.
REQ-009 req_err  out  N_PORTS  one-cycle timeout pulse, coincident with req_valid.
REQ-010 rd_data  out  DATA_W  registered read data, valid while any req_valid bit is high.
REQ-011 mem_en, mem_wr_en  out  1 each  memory start/hold and direction.
REQ-012 mem_addr  out  ADDR_W;  mem_wr_data  out  DATA_W  muxed from granted port.
REQ-013 mem_valid  in  1  memory completion;  mem_rd_data  in  DATA_W  read data, sampled when mem_valid high.
REQ-014 grant  out  N_PORTS  one-hot owner of memory, zero when idle.

Function
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->BUSY when any req_en high; BUSY->DONE on mem_valid or timeout; DONE->IDLE always.
REQ-016 Arbitration in IDLE only, round-robin: search starts at port (last+1) mod N_PORTS; winner registered into grant and last.
REQ-017 req_en sampled in DONE ignored; the completed port must drop req_en by the following IDLE cycle or it is eligible again at lowest rotation priority.
REQ-018 BUSY: mem_en=1, mem_addr/mem_wr_en/mem_wr_data registered from granted port at IDLE->BUSY edge, held constant through BUSY.
REQ-019 mem_en deasserts on the edge where mem_valid is sampled high; never high in IDLE or DONE.
REQ-020 Latency: req_en seen in IDLE cycle t -> mem_en high t+1 -> mem_valid at t+k -> req_valid[i] at t+k+1; minimum transaction period 3 cycles.
REQ-021 rd_data captured from mem_rd_data on mem_valid for reads; holds previous value for writes.
REQ-022 Timeout counter clears on IDLE->BUSY, increments each BUSY cycle; at count TIMEOUT-1 without mem_valid: drop mem_en, go DONE, pulse req_valid and req_err of granted port, rd_data=0.
REQ-023 mem_valid and timeout in same cycle: mem_valid wins, no req_err.
REQ-024 mem_valid outside BUSY ignored.
REQ-025 Grant-holder dropping req_en during BUSY does not abort; transaction completes, req_valid still pulses.

Reset
REQ-026 rst synchronous, dominant over all transitions including mid-BUSY: state IDLE, mem_en=0, grant=0, req_valid=0, req_err=0, rd_data=0, mem_addr=0, mem_wr_data=0, mem_wr_en=0, counter=0, last=N_PORTS-1 (port 0 first).
REQ-027 Transaction in flight at reset is dropped without req_valid.

Structure
REQ-028 Shared package go_mem_pkg holds FSM state encoding, ADDR_W/DATA_W defaults and board-cell data constants.
REQ-029 One sub-module rr_pick: combinational round-robin selector (req vector, last index -> one-hot winner, index).

Verification
REQ-030 Single read: port1 req_en, addr=5, emulator returns 0x02 after 4 cycles -> req_valid[1] one pulse, rd_data=0x02, mem_en high exactly 4 cycles.
REQ-031 Contention: all 3 ports request continuously after reset -> grant order 0,1,2,0,1,2; each req_valid exactly once per turn.
REQ-032 Full clear: port0 writes 0 to addrs 0..63 while port2 reads repeatedly -> all 64 cells 0, port2 never starved more than 1 turn.
REQ-033 Timeout: TIMEOUT=16, memory never answers -> mem_en drops after 16 BUSY cycles, req_valid[i] and req_err[i] pulse together, rd_data=0; mem_valid on cycle 16 -> no req_err.
REQ-034 Reset mid-BUSY: rst at 2nd BUSY cycle -> next cycle mem_en=0, grant=0, no req_valid; next request served port 0 first.
